// File: rtl/load_use_stall_ctrl.sv
// Load-use hazard controller for the ID stage: detects a load destination read by IF/ID,
// holds the front end for LOAD_LAT cycles, lets branch flushes pre-empt, and counts events.
module load_use_stall_ctrl #(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned LOAD_LAT   = 1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [REG_ADDR_W-1:0] RS_addr_IFID_i,
  input  logic [REG_ADDR_W-1:0] RT_addr_IFID_i,
  input  logic                  RS_used_i,
  input  logic                  RT_used_i,
  input  logic [REG_ADDR_W-1:0] RT_addr_IDEX_i,
  input  logic                  MemRead_IDEX_i,
  input  logic                  Branch_flush_i,
  output logic                  Haz_pc_o,
  output logic                  Haz_IFID_o,
  output logic                  Haz_IF_Flush_o,
  output logic                  Haz_ID_Flush_o,
  output logic                  Haz_EX_Flush_o,
  output logic                  stall_busy_o,
  output logic [CNT_W-1:0]      stall_cycles_o,
  output logic [CNT_W-1:0]      lu_events_o
);

  localparam int unsigned CNT_LAT_W = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    STALL = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_LAT_W-1:0]  cnt_q, cnt_d;
  logic [REG_ADDR_W-1:0] pend_q, pend_d;
  logic [CNT_W-1:0]      stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0]      lu_events_q, lu_events_d;
  logic                  hit;
  logic                  lu_inc;

  // Register 0 is hardwired, so a load targeting it never creates a dependency.
  assign hit = MemRead_IDEX_i && (RT_addr_IDEX_i != '0) &&
               ((RS_used_i && (RS_addr_IFID_i == RT_addr_IDEX_i)) ||
                (RT_used_i && (RT_addr_IFID_i == RT_addr_IDEX_i)));

  // Next state and Mealy hazard outputs; flush pre-empts any stall.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    pend_d         = pend_q;
    lu_inc         = 1'b0;
    Haz_pc_o       = 1'b1;
    Haz_IFID_o     = 1'b0;
    Haz_IF_Flush_o = 1'b0;
    Haz_ID_Flush_o = 1'b0;
    Haz_EX_Flush_o = 1'b0;
    if (rst_i) begin
      state_d = IDLE;
      cnt_d   = '0;
      pend_d  = '0;
    end else if (Branch_flush_i) begin
      Haz_IF_Flush_o = 1'b1;
      Haz_ID_Flush_o = 1'b1;
      Haz_EX_Flush_o = 1'b1;
      state_d        = IDLE;
      cnt_d          = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (hit) begin
            Haz_pc_o       = 1'b0;
            Haz_IFID_o     = 1'b1;
            Haz_ID_Flush_o = 1'b1;
            lu_inc         = 1'b1;
            if (LOAD_LAT > 1) begin
              state_d = STALL;
              cnt_d   = CNT_LAT_W'(LOAD_LAT - 1);
              pend_d  = RT_addr_IDEX_i;
            end
          end
        end
        STALL: begin
          Haz_pc_o       = 1'b0;
          Haz_IFID_o     = 1'b1;
          Haz_ID_Flush_o = 1'b1;
          cnt_d          = cnt_q - CNT_LAT_W'(1);
          if (cnt_q == CNT_LAT_W'(1)) begin
            state_d = IDLE;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Saturating performance counters.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    lu_events_d    = lu_events_q;
    if (rst_i) begin
      stall_cycles_d = '0;
      lu_events_d    = '0;
    end else begin
      if (!Haz_pc_o && (stall_cycles_q != '1)) begin
        stall_cycles_d = stall_cycles_q + CNT_W'(1);
      end
      if (lu_inc && (lu_events_q != '1)) begin
        lu_events_d = lu_events_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    state_q        <= state_d;
    cnt_q          <= cnt_d;
    pend_q         <= pend_d;
    stall_cycles_q <= stall_cycles_d;
    lu_events_q    <= lu_events_d;
  end

  assign stall_busy_o   = (state_q == STALL);
  assign stall_cycles_o = stall_cycles_q;
  assign lu_events_o    = lu_events_q;

endmodule

// File: tb/tb_load_use_stall_ctrl.sv
// Directed bench driving three configurations (LOAD_LAT 1/3/4, one with 2-bit counters)
// from a shared stimulus stream and checking hand-computed expectations.
module tb_load_use_stall_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] rs_a, rt_a, dst;
  logic       rs_u, rt_u, mr, bf;

  logic        pc1, ifid1, iff1, idf1, exf1, busy1;
  logic [1:0]  sc1, lu1;
  logic        pc3, ifid3, iff3, idf3, exf3, busy3;
  logic [15:0] sc3, lu3;
  logic        pc4, ifid4, iff4, idf4, exf4, busy4;
  logic [15:0] sc4, lu4;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  load_use_stall_ctrl #(.REG_ADDR_W(5), .LOAD_LAT(1), .CNT_W(2)) d1 (
    .clk_i(clk), .rst_i(rst), .RS_addr_IFID_i(rs_a), .RT_addr_IFID_i(rt_a),
    .RS_used_i(rs_u), .RT_used_i(rt_u), .RT_addr_IDEX_i(dst), .MemRead_IDEX_i(mr),
    .Branch_flush_i(bf), .Haz_pc_o(pc1), .Haz_IFID_o(ifid1), .Haz_IF_Flush_o(iff1),
    .Haz_ID_Flush_o(idf1), .Haz_EX_Flush_o(exf1), .stall_busy_o(busy1),
    .stall_cycles_o(sc1), .lu_events_o(lu1));

  load_use_stall_ctrl #(.REG_ADDR_W(5), .LOAD_LAT(3), .CNT_W(16)) d3 (
    .clk_i(clk), .rst_i(rst), .RS_addr_IFID_i(rs_a), .RT_addr_IFID_i(rt_a),
    .RS_used_i(rs_u), .RT_used_i(rt_u), .RT_addr_IDEX_i(dst), .MemRead_IDEX_i(mr),
    .Branch_flush_i(bf), .Haz_pc_o(pc3), .Haz_IFID_o(ifid3), .Haz_IF_Flush_o(iff3),
    .Haz_ID_Flush_o(idf3), .Haz_EX_Flush_o(exf3), .stall_busy_o(busy3),
    .stall_cycles_o(sc3), .lu_events_o(lu3));

  load_use_stall_ctrl #(.REG_ADDR_W(5), .LOAD_LAT(4), .CNT_W(16)) d4 (
    .clk_i(clk), .rst_i(rst), .RS_addr_IFID_i(rs_a), .RT_addr_IFID_i(rt_a),
    .RS_used_i(rs_u), .RT_used_i(rt_u), .RT_addr_IDEX_i(dst), .MemRead_IDEX_i(mr),
    .Branch_flush_i(bf), .Haz_pc_o(pc4), .Haz_IFID_o(ifid4), .Haz_IF_Flush_o(iff4),
    .Haz_ID_Flush_o(idf4), .Haz_EX_Flush_o(exf4), .stall_busy_o(busy4),
    .stall_cycles_o(sc4), .lu_events_o(lu4));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic [4:0] rs, input logic [4:0] rt, input logic rsu,
                        input logic rtu, input logic [4:0] d, input logic m, input logic b);
    rs_a = rs; rt_a = rt; rs_u = rsu; rt_u = rtu; dst = d; mr = m; bf = b;
    #1;
  endtask

  task automatic idle_in();
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_in();
    tick();
    rst = 1'b0;
    #1;
  endtask

  initial begin
    // Reset cycle with a live hazard on the inputs: outputs must stay idle.
    rst = 1'b1;
    set_in(5'd2, 5'd0, 1'b1, 1'b0, 5'd2, 1'b1, 1'b0);
    chk("rst_pc1", 32'(pc1), 32'd1);
    chk("rst_pc4", 32'(pc4), 32'd1);
    tick();
    rst = 1'b0;
    idle_in();
    chk("post_rst_lu1", 32'(lu1), 32'd0);
    chk("post_rst_sc4", 32'(sc4), 32'd0);
    chk("post_rst_busy4", 32'(busy4), 32'd0);

    // Phase 1: single-cycle rs hit on $2.
    set_in(5'd2, 5'd0, 1'b1, 1'b0, 5'd2, 1'b1, 1'b0);
    chk("p1_pc1", 32'(pc1), 32'd0);
    chk("p1_ifid1", 32'(ifid1), 32'd1);
    chk("p1_idf1", 32'(idf1), 32'd1);
    chk("p1_iff1", 32'(iff1), 32'd0);
    chk("p1_exf1", 32'(exf1), 32'd0);
    tick();
    idle_in();
    chk("p1c1_pc1", 32'(pc1), 32'd1);
    chk("p1c1_lu1", 32'(lu1), 32'd1);
    chk("p1c1_sc1", 32'(sc1), 32'd1);
    chk("p1c1_busy1", 32'(busy1), 32'd0);
    chk("p1c1_pc3", 32'(pc3), 32'd0);
    chk("p1c1_busy3", 32'(busy3), 32'd1);
    tick();
    chk("p1c2_pc3", 32'(pc3), 32'd0);
    chk("p1c2_busy3", 32'(busy3), 32'd1);
    tick();
    chk("p1c3_pc3", 32'(pc3), 32'd1);
    chk("p1c3_busy3", 32'(busy3), 32'd0);
    chk("p1c3_sc3", 32'(sc3), 32'd3);
    chk("p1c3_lu3", 32'(lu3), 32'd1);
    chk("p1c3_pc4", 32'(pc4), 32'd0);
    chk("p1c3_busy4", 32'(busy4), 32'd1);
    tick();
    chk("p1c4_pc4", 32'(pc4), 32'd1);
    chk("p1c4_sc4", 32'(sc4), 32'd4);
    do_reset();

    // Phase 2: rt hit on $7 held for five cycles (rs matches but is unused).
    set_in(5'd7, 5'd7, 1'b0, 1'b1, 5'd7, 1'b1, 1'b0);
    chk("p2c0_pc3", 32'(pc3), 32'd0);
    tick(); tick(); tick();
    chk("p2c3_pc3_backtoback", 32'(pc3), 32'd0);
    chk("p2c3_busy3", 32'(busy3), 32'd0);
    tick();
    chk("p2c4_busy3", 32'(busy3), 32'd1);
    chk("p2c4_lu1_sat", 32'(lu1), 32'd3);
    chk("p2c4_lu3", 32'(lu3), 32'd2);
    tick();
    idle_in();
    chk("p2c5_pc1", 32'(pc1), 32'd1);
    chk("p2c5_sc1_sat", 32'(sc1), 32'd3);
    chk("p2c5_pc3", 32'(pc3), 32'd0);
    chk("p2c5_busy4", 32'(busy4), 32'd1);
    tick();
    chk("p2c6_pc3", 32'(pc3), 32'd1);
    chk("p2c6_sc3", 32'(sc3), 32'd6);
    // Reset in the middle of d4's second stall.
    rst = 1'b1;
    #1;
    chk("p2_rst_pc4", 32'(pc4), 32'd1);
    tick();
    rst = 1'b0;
    #1;
    chk("p2_after_rst_pc4", 32'(pc4), 32'd1);
    chk("p2_after_rst_busy4", 32'(busy4), 32'd0);
    chk("p2_after_rst_sc4", 32'(sc4), 32'd0);
    chk("p2_after_rst_lu4", 32'(lu4), 32'd0);
    chk("p2_after_rst_lu1", 32'(lu1), 32'd0);

    // Phase 3: no hazard for a load to $0 or an unused rt match.
    set_in(5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0);
    chk("p3_zero_pc3", 32'(pc3), 32'd1);
    tick();
    set_in(5'd3, 5'd5, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0);
    chk("p3_rtunused_pc3", 32'(pc3), 32'd1);
    tick();
    idle_in();
    chk("p3_lu3", 32'(lu3), 32'd0);
    chk("p3_sc3", 32'(sc3), 32'd0);

    // Phase 4: flush in the second stall cycle aborts the stall.
    set_in(5'd9, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0);
    tick();
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1);
    chk("p4_pc4", 32'(pc4), 32'd1);
    chk("p4_ifid4", 32'(ifid4), 32'd0);
    chk("p4_iff4", 32'(iff4), 32'd1);
    chk("p4_idf4", 32'(idf4), 32'd1);
    chk("p4_exf4", 32'(exf4), 32'd1);
    chk("p4_ifid3", 32'(ifid3), 32'd0);
    chk("p4_iff3", 32'(iff3), 32'd1);
    chk("p4_idf3", 32'(idf3), 32'd1);
    chk("p4_exf3", 32'(exf3), 32'd1);
    tick();
    idle_in();
    chk("p4_busy4", 32'(busy4), 32'd0);
    chk("p4_pc4_after", 32'(pc4), 32'd1);
    chk("p4_sc4", 32'(sc4), 32'd1);
    chk("p4_lu4", 32'(lu4), 32'd1);
    do_reset();

    // Phase 5: hit and flush together, flush wins.
    set_in(5'd4, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 1'b1);
    chk("p5_pc1", 32'(pc1), 32'd1);
    chk("p5_iff1", 32'(iff1), 32'd1);
    chk("p5_idf1", 32'(idf1), 32'd1);
    chk("p5_exf1", 32'(exf1), 32'd1);
    chk("p5_pc3", 32'(pc3), 32'd1);
    tick();
    idle_in();
    chk("p5_lu1", 32'(lu1), 32'd0);
    chk("p5_lu3", 32'(lu3), 32'd0);
    chk("p5_busy3", 32'(busy3), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/load_use_stall_ctrl.md
# load_use_stall_ctrl

Parametrised load-use hazard controller for the pipelined MIPS CPU, located in the ID stage beside the forwarding unit. It detects a load in ID/EX whose destination register is read by the instruction in IF/ID, and stalls for a configurable number of cycles so it can serve multi-cycle data memories. Branch-flush requests have priority over a stall and abort any stall in progress. The block also maintains saturating performance counters for stall cycles and load-use events.

## Interface
- REG_ADDR_W, 5, register-address width
- LOAD_LAT, 1, stall cycles per load-use hazard (legal 1..15)
- CNT_W, 16, width of each performance counter
- clk_i  in  1  clock; every register updates on the rising edge
- rst_i  in  1  reset, synchronous and active-high
- RS_addr_IFID_i  in  REG_ADDR_W  rs field of the instruction in IF/ID
- RT_addr_IFID_i  in  REG_ADDR_W  rt field of the instruction in IF/ID
- RS_used_i  in  1  instruction in IF/ID reads rs
- RT_used_i  in  1  instruction in IF/ID reads rt
- RT_addr_IDEX_i  in  REG_ADDR_W  destination of the instruction in ID/EX
- MemRead_IDEX_i  in  1  instruction in ID/EX is a load
- Branch_flush_i  in  1  taken branch or jump resolved this cycle
- Haz_pc_o  out  1  PC write enable (1 = write)
- Haz_IFID_o  out  1  IF/ID hold (1 = hold)
- Haz_IF_Flush_o  out  1  zero IF/ID
- Haz_ID_Flush_o  out  1  zero ID/EX controls (bubble)
- Haz_EX_Flush_o  out  1  zero EX/MEM controls
- stall_busy_o  out  1  FSM is in STALL (registered)
- stall_cycles_o  out  CNT_W  number of cycles with Haz_pc_o=0, saturating
- lu_events_o  out  CNT_W  number of load-use hazards detected, saturating

## Operation
- hit = MemRead_IDEX_i & (RT_addr_IDEX_i != 0) & ((RS_used_i & RS_addr_IFID_i==RT_addr_IDEX_i) | (RT_used_i & RT_addr_IFID_i==RT_addr_IDEX_i)).
- Register 0 never causes a hazard.
- FSM states are IDLE and STALL. cnt is a 4-bit down-counter; pend_reg holds the latched load destination and is used for debug only.
- Stall outputs: Haz_pc_o=0, Haz_IFID_o=1, Haz_ID_Flush_o=1, Haz_IF_Flush_o=0, Haz_EX_Flush_o=0.
- Idle outputs: Haz_pc_o=1, and all other hazard outputs are 0.
- Flush outputs (Branch_flush_i=1, in any state): Haz_pc_o=1, Haz_IFID_o=0, Haz_IF_Flush_o=1, Haz_ID_Flush_o=1, Haz_EX_Flush_o=1.
- IDLE with Branch_flush_i=1:
  - Drive flush outputs.
  - Stay in IDLE.
  - Do not count an event, even if hit=1.
- IDLE with hit=1 and no flush:
  - Drive stall outputs this cycle, which is a Mealy response.
  - Increment lu_events.
  - If LOAD_LAT>1: go to STALL, load cnt=LOAD_LAT-1, latch pend_reg=RT_addr_IDEX_i.
  - If LOAD_LAT==1: stay in IDLE.
- STALL with no flush:
  - Drive stall outputs; hit is ignored.
  - cnt decrements each cycle.
  - When cnt==1, go to IDLE on the next edge.
- STALL with Branch_flush_i=1:
  - Drive flush outputs.
  - Go to IDLE and clear cnt.
  - The stall is abandoned.
- Counters:
  - stall_cycles increments on every cycle with Haz_pc_o=0.
  - Both counters saturate at 2^CNT_W-1 and never wrap.
- Reset (rst_i=1):
  - Next state is IDLE; cnt=0, pend_reg=0, both counters 0, stall_busy_o=0.
  - During the reset cycle, outputs are forced to idle values regardless of the other inputs.
  - Reset during STALL aborts the stall.

## Timing
- Detection to outputs is combinational, with zero-cycle latency.
- FSM, cnt and counters update on the rising edge of clk_i.
- A hazard holds the PC for exactly LOAD_LAT consecutive cycles: the detect cycle plus LOAD_LAT-1 cycles in STALL.
- The first instruction after the stall may itself hit against a new load in ID/EX. It is detected in the first IDLE cycle after the stall, and the two stalls run back to back.
- stall_busy_o is high from the cycle after detection until the last stall cycle, inclusive. It is always low when LOAD_LAT==1.
- Counter values are visible one cycle after the event cycle.
- Branch_flush_i and hit in the same cycle: the flush wins and no stall occurs.

## Test plan
- LOAD_LAT=1, lw $2 in ID/EX, add reading $2 as rs in IF/ID:
  - Haz_pc_o=0, Haz_IFID_o=1 and Haz_ID_Flush_o=1 for 1 cycle.
  - lu_events_o=1 and stall_cycles_o=1 afterwards.
- LOAD_LAT=3, same hazard via rt:
  - Haz_pc_o=0 for exactly 3 cycles.
  - stall_busy_o high for cycles 2-3.
  - stall_cycles_o=3.
- Load to $0 with a matching rs, and load to $5 where RT_used_i=0 and rt=5: no stall, and counters stay 0.
- LOAD_LAT=4, Branch_flush_i pulsed in the second stall cycle:
  - That cycle drives flush outputs with Haz_pc_o=1.
  - The FSM is in IDLE next cycle; stall_cycles_o=1.
- Hit and Branch_flush_i asserted together:
  - Haz_IF_Flush_o=1, Haz_ID_Flush_o=1, Haz_EX_Flush_o=1, Haz_pc_o=1.
  - lu_events_o stays 0.
- CNT_W=2, 5 separate hazards: lu_events_o saturates at 3. Then rst_i for 1 cycle mid-stall: next cycle Haz_pc_o=1 and both counters 0.
